pkt_buf_rd_arb: RTL and testbench

PKT_BUF_RD_ARB -- requirements
Module: pkt_buf_rd_arb

---
 rtl/pkt_buf_rd_arb.sv | 161 ++++++++++++++++
 tb/tb_pkt_buf_rd_arb.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/pkt_buf_rd_arb.sv
// pkt_buf_rd_arb: arbitrates read requests from NUM_REQ requesters onto a single
// packet-buffer read port and routes the in-order read returns back to their owners.
//
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   req_valid/req_addr  - per-requester read request and address (slice i*AWIDTH)
//   req_ready           - combinational one-hot grant
//   pkt_buf_rden/_rdaddress     - registered read command to the buffer
//   pkt_buf_rd_valid/_rddata    - read return from the buffer (in order)
//   resp_valid/resp_data/resp_id - registered response and its owner
//   outstanding         - number of reads in flight
//   err_underflow       - sticky: a read return arrived with nothing in flight
//
// Build option: define PKT_BUF_RD_FIXED_PRIO_EN for strict fixed priority (lowest
// index wins, no priority pointer); default is round-robin.
//
// NUM_REQ must be at least 2 and MAX_OUT a power of two of at least 2.

module pkt_buf_rd_arb #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned AWIDTH  = 15,
    parameter int unsigned DWIDTH  = 520,
    parameter int unsigned MAX_OUT = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*AWIDTH-1:0]    req_addr,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         pkt_buf_rden,
    output logic [AWIDTH-1:0]            pkt_buf_rdaddress,
    input  logic                         pkt_buf_rd_valid,
    input  logic [DWIDTH-1:0]            pkt_buf_rddata,
    output logic                         resp_valid,
    output logic [DWIDTH-1:0]            resp_data,
    output logic [$clog2(NUM_REQ)-1:0]   resp_id,
    output logic [$clog2(MAX_OUT):0]     outstanding,
    output logic                         err_underflow
);

    localparam int unsigned IDW = $clog2(NUM_REQ);
    localparam int unsigned PW  = $clog2(MAX_OUT);
    localparam int unsigned OW  = PW + 1;

    logic              full;
    logic              grant_any;
    logic [IDW-1:0]    grant_idx;
    logic [AWIDTH-1:0] grant_addr;
    logic              pop;

    logic [IDW-1:0]    tag_mem [MAX_OUT];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;

    // A pop in the same cycle does not free a slot for a grant: the full check
    // uses the registered count only.
    assign full = (outstanding == OW'(MAX_OUT));
    assign pop  = pkt_buf_rd_valid && (outstanding != '0);

`ifdef PKT_BUF_RD_FIXED_PRIO_EN
    always_comb begin
        logic [IDW-1:0] cand;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDW'(i);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (rst || full) begin
            grant_any = 1'b0;
        end
    end
`else
    logic [IDW-1:0] rr_ptr;

    // Search upward from the priority pointer, wrapping modulo NUM_REQ.
    always_comb begin
        int unsigned    sum;
        logic [IDW-1:0] cand;
        grant_any = 1'b0;
        grant_idx = '0;
        sum       = 0;
        cand      = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sum = 32'(rr_ptr) + i;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            cand = IDW'(sum);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_idx = cand;
            end
        end
        if (rst || full) begin
            grant_any = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (grant_any) begin
            rr_ptr <= (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end
`endif

    assign req_ready  = grant_any ? (NUM_REQ'(1) << grant_idx) : '0;
    assign grant_addr = req_addr[32'(grant_idx)*AWIDTH +: AWIDTH];

    // Tag storage holds only requester ids; no reset needed, pointers guard it.
    always_ff @(posedge clk) begin
        if (grant_any) begin
            tag_mem[wr_ptr] <= grant_idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pkt_buf_rden      <= 1'b0;
            pkt_buf_rdaddress <= '0;
            resp_valid        <= 1'b0;
            resp_data         <= '0;
            resp_id           <= '0;
            outstanding       <= '0;
            err_underflow     <= 1'b0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
        end else begin
            pkt_buf_rden <= grant_any;
            if (grant_any) begin
                pkt_buf_rdaddress <= grant_addr;
                wr_ptr            <= wr_ptr + 1'b1;
            end

            resp_valid <= pop;
            if (pop) begin
                resp_data <= pkt_buf_rddata;
                resp_id   <= tag_mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
            end

            // Returns with nothing in flight (e.g. reads issued before a reset).
            if (pkt_buf_rd_valid && (outstanding == '0)) begin
                err_underflow <= 1'b1;
            end

            case ({grant_any, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

endmodule

// File: tb/tb_pkt_buf_rd_arb.sv
// Directed bench for pkt_buf_rd_arb with a scoreboard: expected read addresses and
// responses are queued when stimulus is driven and compared when the DUT emits them.
module tb_pkt_buf_rd_arb;

    localparam int NR = 4;
    localparam int AW = 15;
    localparam int DW = 520;
    localparam int MO = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*AW-1:0]  req_addr;
    logic [NR-1:0]     req_ready;
    logic              pkt_buf_rden;
    logic [AW-1:0]     pkt_buf_rdaddress;
    logic              pkt_buf_rd_valid = 1'b0;
    logic [DW-1:0]     pkt_buf_rddata = '0;
    logic              resp_valid;
    logic [DW-1:0]     resp_data;
    logic [1:0]        resp_id;
    logic [3:0]        outstanding;
    logic              err_underflow;

    always #5 clk = ~clk;

    pkt_buf_rd_arb #(
        .NUM_REQ (NR),
        .AWIDTH  (AW),
        .DWIDTH  (DW),
        .MAX_OUT (MO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_valid         (req_valid),
        .req_addr          (req_addr),
        .req_ready         (req_ready),
        .pkt_buf_rden      (pkt_buf_rden),
        .pkt_buf_rdaddress (pkt_buf_rdaddress),
        .pkt_buf_rd_valid  (pkt_buf_rd_valid),
        .pkt_buf_rddata    (pkt_buf_rddata),
        .resp_valid        (resp_valid),
        .resp_data         (resp_data),
        .resp_id           (resp_id),
        .outstanding       (outstanding),
        .err_underflow     (err_underflow)
    );

    typedef struct {
        logic [1:0]    id;
        logic [DW-1:0] data;
    } resp_t;

    logic [AW-1:0] m_addr [NR];
    logic [AW-1:0] addr_q [$];
    resp_t         resp_q [$];
    logic [1:0]    tag_q  [$];
    int            m_ptr;
    int            m_out;
    bit            m_err;
    bit            exp_rden;
    bit            exp_resp;
    int            tests = 0;
    int            fails = 0;

    task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1: checks what the last edge registered, drives new inputs,
    // checks the combinational grant, updates the model, then advances one clock.
    task automatic cycle(input logic [NR-1:0] v, input logic rv, input logic [DW-1:0] rdata);
        logic [AW-1:0] ea;
        resp_t         r;
        int            g;
        int            c;
        int            old_out;
        if (exp_rden) begin
            ea = addr_q.pop_front();
            check("rden", pkt_buf_rden, 1);
            check("rdaddress", pkt_buf_rdaddress, ea);
        end else begin
            check("rden_idle", pkt_buf_rden, 0);
        end
        if (exp_resp) begin
            r = resp_q.pop_front();
            check("resp_valid", resp_valid, 1);
            check("resp_id", resp_id, r.id);
            check("resp_data", resp_data, r.data);
        end else begin
            check("resp_idle", resp_valid, 0);
        end
        check("outstanding", outstanding, m_out);
        check("err_underflow", err_underflow, m_err);

        req_valid        = v;
        pkt_buf_rd_valid = rv;
        pkt_buf_rddata   = rdata;
        #1;
        g = -1;
        if (m_out < MO) begin
            for (int k = 0; k < NR; k++) begin
`ifdef PKT_BUF_RD_FIXED_PRIO_EN
                c = k;
`else
                c = (m_ptr + k) % NR;
`endif
                if (g < 0 && v[c[1:0]]) g = c;
            end
        end
        check("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
        exp_rden = (g >= 0);
        if (g >= 0) begin
            addr_q.push_back(m_addr[g]);
            tag_q.push_back(g[1:0]);
            m_ptr = (g + 1) % NR;
        end
        old_out  = m_out;
        exp_resp = 1'b0;
        if (rv) begin
            if (old_out == 0) begin
                m_err = 1'b1;
            end else begin
                r.id   = tag_q.pop_front();
                r.data = rdata;
                resp_q.push_back(r);
                exp_resp = 1'b1;
            end
        end
        m_out = old_out + ((g >= 0) ? 1 : 0) - ((rv && old_out > 0) ? 1 : 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst              = 1'b1;
        req_valid        = '1;
        pkt_buf_rd_valid = 1'b0;
        #2;
        check("rst_ready", req_ready, 0);
        check("rst_rden", pkt_buf_rden, 0);
        check("rst_rdaddress", pkt_buf_rdaddress, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_id", resp_id, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_err", err_underflow, 0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = '0;
        m_ptr     = 0;
        m_out     = 0;
        m_err     = 1'b0;
        exp_rden  = 1'b0;
        exp_resp  = 1'b0;
        addr_q.delete();
        resp_q.delete();
        tag_q.delete();
    endtask

    initial begin
        m_addr[0] = 15'h10;
        m_addr[1] = 15'h20;
        m_addr[2] = 15'h30;
        m_addr[3] = 15'h40;
        req_addr  = {m_addr[3], m_addr[2], m_addr[1], m_addr[0]};

        do_reset();

        // All requesters valid: round-robin sweep (fixed priority under the macro).
        repeat (8) cycle(4'hF, 1'b0, '0);

        // Eight reads in flight: no grant, even with a return in the same cycle.
        cycle(4'hF, 1'b0, '0);
        check("full_ready", req_ready, 0);
        check("full_count", outstanding, 8);
        cycle(4'hF, 1'b1, DW'(32'h55));
        check("after_pop_count", outstanding, 7);
        cycle(4'hF, 1'b0, '0);
        for (int k = 0; k < 8; k++) cycle(4'h0, 1'b1, DW'(32'h100 + k));
        cycle(4'h0, 1'b0, '0);

        // Grants to 2, 0, 3 then back-to-back returns A, B, C.
        cycle(4'b0100, 1'b0, '0);
        cycle(4'b0001, 1'b0, '0);
        cycle(4'b1000, 1'b0, '0);
        cycle(4'h0, 1'b1, DW'(32'hA));
        cycle(4'h0, 1'b1, DW'(32'hB));
        cycle(4'h0, 1'b1, DW'(32'hC));
        cycle(4'h0, 1'b0, '0);

        // Grant and return in the same cycle at a count of three.
        repeat (3) cycle(4'b0001, 1'b0, '0);
        cycle(4'b0010, 1'b1, DW'(32'hD));
        check("same_cycle_count", outstanding, 3);
        repeat (3) cycle(4'h0, 1'b1, DW'(32'h77));
        cycle(4'h0, 1'b0, '0);

        // Reset with two reads in flight; the late return is an underflow.
        cycle(4'hF, 1'b0, '0);
        cycle(4'hF, 1'b0, '0);
        do_reset();
        cycle(4'h0, 1'b1, DW'(32'hE));
        cycle(4'h0, 1'b0, '0);
        check("underflow_flag", err_underflow, 1);
        check("underflow_count", outstanding, 0);
        check("underflow_no_resp", resp_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
